// File: rtl/cache_trace_if.sv
// Cache read-port bundle between the trace driver (master) and a cache model (slave).
interface cache_trace_if #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  read;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  hit;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (output read, output addr, input hit, input read_data);
   modport slave  (input read, input addr, output hit, output read_data);
endinterface

// File: rtl/cache_trace_driver.sv
// Replays a loadable address trace on a cache read port and accumulates hit/miss statistics.
// Optional data signature output enabled by defining CACHE_TRACE_SIG_EN.
module cache_trace_driver #(
   parameter int unsigned ADDR_WIDTH    = 11,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned TRACE_DEPTH   = 16,
   parameter int unsigned IDX_WIDTH     = 4,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [IDX_WIDTH-1:0]  load_idx,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [IDX_WIDTH:0]    trace_len,
   input  logic                  start,
   cache_trace_if.master         bus,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  access_cnt,
   output logic [CNT_WIDTH-1:0]  hit_cnt,
   output logic [CNT_WIDTH-1:0]  miss_cnt
`ifdef CACHE_TRACE_SIG_EN
   ,
   output logic [DATA_WIDTH-1:0] data_sig
`endif
);
   localparam int unsigned LEN_W  = IDX_WIDTH + 1;
   localparam int unsigned WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [LEN_W-1:0]     DEPTH_L = LEN_W'(TRACE_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SAMPLE, DONE} state_t;

   state_t                state;
   logic [LEN_W-1:0]      len;
   logic [IDX_WIDTH-1:0]  idx;
   logic [WAIT_W-1:0]     wcnt;
   logic [ADDR_WIDTH-1:0] trace_mem [TRACE_DEPTH];

   logic                  idle_c, load_ok_c, start_ok_c, last_c;
   logic [LEN_W-1:0]      len_c;
   logic [IDX_WIDTH-1:0]  next_idx_c;
   logic [ADDR_WIDTH-1:0] first_addr_c;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign idle_c     = (state == IDLE) || (state == DONE);
   assign load_ok_c  = load_en && idle_c;
   assign start_ok_c = start && idle_c;
   assign len_c      = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
   assign last_c     = ({1'b0, idx} == (len - LEN_W'(1)));
   assign next_idx_c = idx + IDX_WIDTH'(1);
   // A load in the start cycle must be visible to the first issued entry.
   assign first_addr_c = (load_ok_c && (load_idx == '0)) ? load_addr : trace_mem[0];

   // Trace storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (load_ok_c) trace_mem[load_idx] <= load_addr;
   end

`ifndef CACHE_TRACE_SIG_EN
   logic unused_read_data;
   assign unused_read_data = ^bus.read_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         len        <= '0;
         idx        <= '0;
         wcnt       <= '0;
         bus.read   <= 1'b0;
         bus.addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         access_cnt <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
`ifdef CACHE_TRACE_SIG_EN
         data_sig   <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_ok_c) begin
                  len        <= len_c;
                  idx        <= '0;
                  access_cnt <= '0;
                  hit_cnt    <= '0;
                  miss_cnt   <= '0;
`ifdef CACHE_TRACE_SIG_EN
                  data_sig   <= '0;
`endif
                  if (len_c == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ISSUE;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     bus.read <= 1'b1;
                     bus.addr <= first_addr_c;
                  end
               end
            end
            ISSUE: begin
               bus.read <= 1'b0;
               wcnt     <= WAIT_W'(SETTLE_CYCLES - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wcnt == '0) state <= SAMPLE;
               else            wcnt  <= wcnt - WAIT_W'(1);
            end
            SAMPLE: begin
               access_cnt <= sat_inc(access_cnt);
               if (bus.hit) hit_cnt  <= sat_inc(hit_cnt);
               else         miss_cnt <= sat_inc(miss_cnt);
`ifdef CACHE_TRACE_SIG_EN
               data_sig <= {data_sig[DATA_WIDTH-2:0], data_sig[DATA_WIDTH-1]} ^ bus.read_data;
`endif
               if (last_c) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx      <= next_idx_c;
                  bus.addr <= trace_mem[next_idx_c];
                  bus.read <= 1'b1;
                  state    <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_trace_driver.sv
// Self-checking bench for cache_trace_driver: random traces against a trace-level hit/miss model.
module tb_cache_trace_driver;
   localparam int unsigned AW = 11;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_en;
   logic [3:0]    load_idx;
   logic [AW-1:0] load_addr;
   logic [4:0]    trace_len;
   logic          start;
   logic          busy, done;
   logic [CW-1:0] access_cnt, hit_cnt, miss_cnt;
`ifdef CACHE_TRACE_SIG_EN
   logic [DW-1:0] data_sig;
`endif

   cache_trace_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   cache_trace_driver dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr),
      .trace_len(trace_len), .start(start), .bus(bus), .busy(busy), .done(done),
      .access_cnt(access_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`ifdef CACHE_TRACE_SIG_EN
      , .data_sig(data_sig)
`endif
   );

   always #5 clk = ~clk;

   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            start_cyc;
   logic [AW-1:0] tb_trace [16];
   logic [AW-1:0] pulse_addr [$];
   int            pulse_cyc [$];
   bit            seen [int];

   always @(posedge clk) cyc <= cyc + 1;

   // Cache model: an address hits if it was already read in the current replay.
   always @(negedge clk) begin
      if (bus.read === 1'b1) begin
         pulse_addr.push_back(bus.addr);
         pulse_cyc.push_back(cyc);
         bus.hit = seen.exists(int'(bus.addr));
         seen[int'(bus.addr)] = 1'b1;
      end else if (busy !== 1'b1) begin
         bus.hit = 1'($urandom_range(0, 1));
      end
   end

   function automatic int model_hits(input int n);
      bit s [int];
      int h = 0;
      for (int i = 0; i < n; i++) begin
         if (s.exists(int'(tb_trace[i]))) h++;
         s[int'(tb_trace[i])] = 1'b1;
      end
      return h;
   endfunction

   function automatic logic [DW-1:0] model_sig(input int n, input logic [DW-1:0] rd);
      logic [DW-1:0] s = '0;
      for (int i = 0; i < n; i++) s = {s[DW-2:0], s[DW-1]} ^ rd;
      return s;
   endfunction

   task automatic load_entry(input int i, input logic [AW-1:0] a);
      load_en = 1'b1; load_idx = 4'(i); load_addr = a;
      @(posedge clk); #1;
      load_en = 1'b0;
      tb_trace[i] = a;
   endtask

   task automatic launch(input int len);
      pulse_addr.delete(); pulse_cyc.delete(); seen.delete();
      trace_len = 5'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, output int dc, output bit ok);
      ok = 1'b0; dc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin dc = cyc; ok = 1'b1; break; end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if ({bus.read, bus.addr, busy, done, access_cnt, hit_cnt, miss_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc%0d: read=%b addr=%0h busy=%b done=%b acc=%0d hit=%0d miss=%0d want all 0",
                     i, bus.read, bus.addr, busy, done, access_cnt, hit_cnt, miss_cnt);
         end
      end
   endtask

   task automatic test_directed();
      logic [AW-1:0] pat [10] = '{11'h020, 11'h040, 11'h060, 11'h020, 11'h080,
                                  11'h0A0, 11'h040, 11'h0C0, 11'h0E0, 11'h020};
      int dc; bit ok;
      for (int i = 0; i < 10; i++) load_entry(i, pat[i]);
      launch(10);
      total++;
      if (busy !== 1'b1 || bus.read !== 1'b1) begin
         bad++; $display("FAIL dir_busy: busy=%b read=%b want 1 1", busy, bus.read);
      end
      wait_done(100, dc, ok);
      total++;
      if (!ok || dc != start_cyc + 30) begin
         bad++; $display("FAIL dir_done_time: got %0d want %0d", dc - start_cyc, 30);
      end
      total++;
      if (pulse_addr.size() != 10) begin
         bad++; $display("FAIL dir_pulses: got %0d want 10", pulse_addr.size());
      end
      for (int k = 0; k < pulse_addr.size() && k < 10; k++) begin
         total++;
         if (pulse_addr[k] !== pat[k] || pulse_cyc[k] != start_cyc + 3 * k) begin
            bad++;
            $display("FAIL dir_pulse%0d: addr=%0h at +%0d want %0h at +%0d",
                     k, pulse_addr[k], pulse_cyc[k] - start_cyc, pat[k], 3 * k);
         end
      end
      total++;
      if (access_cnt !== 16'd10 || hit_cnt !== 16'd3 || miss_cnt !== 16'd7 || busy !== 1'b0) begin
         bad++;
         $display("FAIL dir_counts: acc=%0d hit=%0d miss=%0d busy=%b want 10 3 7 0",
                  access_cnt, hit_cnt, miss_cnt, busy);
      end
   endtask

   task automatic test_zero_len();
      int dc; bit ok;
      apply_reset();
      launch(0);
      wait_done(10, dc, ok);
      total++;
      if (!ok || dc != start_cyc || pulse_addr.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_len: done_at=+%0d pulses=%0d busy=%b want +0 0 0",
                  dc - start_cyc, pulse_addr.size(), busy);
      end
      total++;
      if ({access_cnt, hit_cnt, miss_cnt} !== '0) begin
         bad++; $display("FAIL zero_len_cnt: acc=%0d hit=%0d miss=%0d want 0", access_cnt, hit_cnt, miss_cnt);
      end
   endtask

   task automatic run_random(input string name, input int len_req);
      int dc; bit ok; int len; int eh;
      logic [DW-1:0] rd;
      len = (len_req > 16) ? 16 : len_req;
      for (int i = 0; i < 16; i++) load_entry(i, AW'($urandom_range(0, 7) * 32));
      rd = $urandom;
      bus.read_data = rd;
      eh = model_hits(len);
      launch(len_req);
      wait_done(len * 3 + 10, dc, ok);
      total++;
      if (!ok || dc != start_cyc + 3 * len || pulse_addr.size() != len) begin
         bad++;
         $display("FAIL %s_timing: done_at=+%0d pulses=%0d want +%0d %0d",
                  name, dc - start_cyc, pulse_addr.size(), 3 * len, len);
      end
      for (int k = 0; k < pulse_addr.size() && k < len; k++) begin
         total++;
         if (pulse_addr[k] !== tb_trace[k]) begin
            bad++; $display("FAIL %s_addr%0d: got %0h want %0h", name, k, pulse_addr[k], tb_trace[k]);
         end
      end
      total++;
      if (access_cnt !== CW'(len) || hit_cnt !== CW'(eh) || miss_cnt !== CW'(len - eh)) begin
         bad++;
         $display("FAIL %s_counts: acc=%0d hit=%0d miss=%0d want %0d %0d %0d",
                  name, access_cnt, hit_cnt, miss_cnt, len, eh, len - eh);
      end
`ifdef CACHE_TRACE_SIG_EN
      total++;
      if (data_sig !== model_sig(len, rd)) begin
         bad++; $display("FAIL %s_sig: got %0h want %0h", name, data_sig, model_sig(len, rd));
      end
`endif
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) run_random("rand", $urandom_range(1, 16));
   endtask

   task automatic test_clamp();
      run_random("clamp", 20);
   endtask

   task automatic test_reset_mid();
      int dc; bit ok; int eh;
      for (int i = 0; i < 16; i++) load_entry(i, AW'($urandom_range(0, 5) * 64));
      eh = model_hits(10);
      launch(10);
      for (int i = 0; i < 40 && pulse_addr.size() < 4; i++) @(negedge clk);
      total++;
      if (pulse_addr.size() < 4) begin
         bad++; $display("FAIL midrst_reach: pulses=%0d want 4", pulse_addr.size());
      end
      rst = 1'b0;
      #1;
      total++;
      if ({bus.read, bus.addr, busy, done, access_cnt, hit_cnt, miss_cnt} !== '0) begin
         bad++;
         $display("FAIL midrst_zero: read=%b addr=%0h busy=%b done=%b acc=%0d want all 0",
                  bus.read, bus.addr, busy, done, access_cnt);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      launch(10);
      wait_done(60, dc, ok);
      total++;
      if (!ok || pulse_addr.size() != 10 || pulse_addr[0] !== tb_trace[0]) begin
         bad++; $display("FAIL midrst_replay: ok=%b pulses=%0d want 1 10", ok, pulse_addr.size());
      end
      total++;
      if (access_cnt !== 16'd10 || hit_cnt !== CW'(eh)) begin
         bad++; $display("FAIL midrst_counts: acc=%0d hit=%0d want 10 %0d", access_cnt, hit_cnt, eh);
      end
   endtask

   task automatic test_busy_ignore();
      int dc; bit ok;
      logic [AW-1:0] orig0;
      for (int i = 0; i < 8; i++) load_entry(i, AW'(i * 16 + 1));
      orig0 = tb_trace[0];
      launch(8);
      repeat (4) @(posedge clk);
      #1 start = 1'b1; load_en = 1'b1; load_idx = 4'd0; load_addr = 11'h7FF; trace_len = 5'd3;
      repeat (2) @(posedge clk);
      #1 start = 1'b0; load_en = 1'b0;
      wait_done(60, dc, ok);
      total++;
      if (!ok || dc != start_cyc + 24 || access_cnt !== 16'd8 || pulse_addr.size() != 8) begin
         bad++;
         $display("FAIL busy_ign_run: done_at=+%0d acc=%0d pulses=%0d want +24 8 8",
                  dc - start_cyc, access_cnt, pulse_addr.size());
      end
      @(posedge clk); #1;
      launch(8);
      wait_done(60, dc, ok);
      total++;
      if (!ok || pulse_addr.size() == 0 || pulse_addr[0] !== orig0) begin
         bad++; $display("FAIL busy_ign_trace: ok=%b entry0 want %0h", ok, orig0);
      end
   endtask

   task automatic test_load_start();
      int dc; bit ok;
      @(posedge clk); #1;
      load_en = 1'b1; load_idx = 4'd0; load_addr = 11'h5A5; tb_trace[0] = 11'h5A5;
      pulse_addr.delete(); pulse_cyc.delete(); seen.delete();
      trace_len = 5'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0; start_cyc = cyc;
      wait_done(20, dc, ok);
      total++;
      if (!ok || pulse_addr.size() != 2 || pulse_addr[0] !== 11'h5A5) begin
         bad++; $display("FAIL load_start: ok=%b pulses=%0d want first addr 5a5", ok, pulse_addr.size());
      end
   endtask

`ifdef CACHE_TRACE_SIG_EN
   task automatic test_sig();
      int dc; bit ok;
      bus.read_data = 32'h0000_0001;
      launch(2);
      wait_done(20, dc, ok);
      total++;
      if (!ok || data_sig !== 32'h0000_0003) begin
         bad++; $display("FAIL sig_const: got %0h want 00000003", data_sig);
      end
   endtask
`endif

   initial begin
      rst = 1'b0; load_en = 1'b0; load_idx = '0; load_addr = '0;
      trace_len = '0; start = 1'b0;
      bus.hit = 1'b0; bus.read_data = '0;
      test_reset();
      test_directed();
      test_zero_len();
      test_random();
      test_clamp();
      test_reset_mid();
      test_busy_ignore();
      test_load_start();
`ifdef CACHE_TRACE_SIG_EN
      test_sig();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
